// File: rtl/pipe_adder_pkg.sv
// Purpose  : shared constants and helpers for the pipelined signed add/sub unit.
// Latency  : n/a (declarations only).
// Backpres.: n/a.
// Contents : OP_ADD/OP_SUB opcodes, default/maximum geometry, sat_value() clamp helper.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_STAGES     = 2;
    localparam int MAX_STAGES         = 8;

    // Widest operand the clamp helper can produce constants for.
    localparam int MAX_DATA_WIDTH = 64;

    // Signed clamp constant for a 'width'-bit result: neg=1 gives MIN (100..0),
    // neg=0 gives MAX (011..1). Only the low 'width' bits are meaningful.
    function automatic logic [MAX_DATA_WIDTH-1:0] sat_value(input logic neg, input int width);
        logic [MAX_DATA_WIDTH-1:0] ones;
        ones = '1;
        if (neg) begin
            sat_value = ones << (width - 1);
        end else begin
            sat_value = ones >> (MAX_DATA_WIDTH - width + 1);
        end
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Purpose  : one valid/ready register slice holding {valid, data}.
// Latency  : 1 cycle from input handshake to out_valid.
// Backpres.: in_ready = !out_valid || out_ready, so a slice refills on the same edge it drains.
// Ports    : clk, rst_n (async active-low); in_valid/in_ready/in_data upstream side;
//            out_valid/out_ready/out_data downstream side.
module pipe_stage #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Slice may load when empty or when its current content leaves this edge.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // Data only moves with a real transfer so an idle slot keeps its last value.
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Purpose  : pipelined signed add/sub (a0 +/- a1) with signed-overflow flag.
// Latency  : STAGES register stages from accepted input to y/out_valid (one result/cycle).
// Backpres.: ready chain through all slices; in_ready drops once all STAGES slots hold data.
// Ports    : clk, rst_n (async active-low); in_valid/in_ready/a0/a1/op producer side;
//            out_valid/out_ready/y/ovf consumer side.
// Build    : define PIPE_ADDER_SAT_EN to clamp y to signed MAX/MIN on overflow;
//            otherwise y is the wrapped mod-2^W result. ovf is reported in both builds.
// Geometry : DATA_WIDTH 2..64, STAGES 1..MAX_STAGES.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STAGES     = DEFAULT_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic                  op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  ovf
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 1;    // slice payload {ovf, y}

    // Arithmetic is done one bit wider than the operands so that negating
    // MIN (e.g. 0 - 0x8000) is exact; overflow is then a mismatch between
    // the true sign (bit W) and the truncated result's sign (bit W-1).
    logic [W:0]   a_ext;
    logic [W:0]   b_ext;
    logic [W:0]   sum_ext;
    logic         ovf_c;
    logic [W-1:0] y_c;

    always_comb begin
        a_ext   = {a0[W-1], a0};
        b_ext   = {a1[W-1], a1};
        sum_ext = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf_c   = sum_ext[W] ^ sum_ext[W-1];
`ifdef PIPE_ADDER_SAT_EN
        // Bit W is the true sign: positive overflow clamps to MAX, negative to MIN.
        y_c = ovf_c ? W'(sat_value(sum_ext[W], W)) : sum_ext[W-1:0];
`else
        y_c = sum_ext[W-1:0];
`endif
    end

    // Index i is the input side of slice i; index STAGES is the pipe output.
    logic          vld [STAGES+1];
    logic          rdy [STAGES+1];
    logic [SW-1:0] dat [STAGES+1];

    assign vld[0]      = in_valid;
    assign dat[0]      = {ovf_c, y_c};
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_stage #(
            .WIDTH(SW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (vld[i]),
            .in_ready (rdy[i]),
            .in_data  (dat[i]),
            .out_valid(vld[i+1]),
            .out_ready(rdy[i+1]),
            .out_data (dat[i+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign ovf       = dat[STAGES][SW-1];
    assign y         = dat[STAGES][W-1:0];

endmodule

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
module tb_pipe_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main DUT: STAGES=2
    logic         in_valid, in_ready, op, out_valid, out_ready, ovf;
    logic [W-1:0] a0, a1, y;
    logic [W:0]   exp_in;     // expected {ovf,y} for whatever is on a0/a1/op now

    pipe_adder #(.DATA_WIDTH(W), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    // Extra builds: [0] STAGES=1, [1] STAGES=8
    logic         x_in_valid [2], x_in_ready [2], x_op [2], x_out_valid [2], x_out_ready [2], x_ovf [2];
    logic [W-1:0] x_a0 [2], x_a1 [2], x_y [2];

    pipe_adder #(.DATA_WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid[0]), .in_ready(x_in_ready[0]),
        .a0(x_a0[0]), .a1(x_a1[0]), .op(x_op[0]), .out_valid(x_out_valid[0]),
        .out_ready(x_out_ready[0]), .y(x_y[0]), .ovf(x_ovf[0])
    );

    pipe_adder #(.DATA_WIDTH(W), .STAGES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid[1]), .in_ready(x_in_ready[1]),
        .a0(x_a0[1]), .a1(x_a1[1]), .op(x_op[1]), .out_valid(x_out_valid[1]),
        .out_ready(x_out_ready[1]), .y(x_y[1]), .ovf(x_ovf[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model using integer arithmetic and range tests.
    function automatic logic [W:0] model(input logic [W-1:0] p, input logic [W-1:0] q, input logic o);
        int          ia, ib, s;
        logic [31:0] sv;
        logic        ov;
        logic [W-1:0] r;
        ia = $signed(p);
        ib = $signed(q);
        s  = o ? (ia - ib) : (ia + ib);
        sv = s;
        ov = (s > 32767) || (s < -32768);
        r  = sv[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (s > 32767) r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
`endif
        return {ov, r};
    endfunction

    // Golden vectors, expected values worked by hand.
    typedef struct {
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic         op;
        logic [W-1:0] y_wrap;
        logic [W-1:0] y_sat;
        logic         ovf;
    } vec_t;
    vec_t vt [9];

    function automatic logic [W:0] vexp(input int i);
`ifdef PIPE_ADDER_SAT_EN
        return {vt[i].ovf, vt[i].y_sat};
`else
        return {vt[i].ovf, vt[i].y_wrap};
`endif
    endfunction

    task automatic apply(input int i);
        a0 = vt[i].a0; a1 = vt[i].a1; op = vt[i].op;
        exp_in = vexp(i);
        in_valid = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Main scoreboard, sampled on the falling edge
    logic [W:0] q_m [$];
    int         pop_cyc [$];
    int         pushes_m = 0, pops_m = 0, cyc = 0;
    logic       held = 1'b0;
    logic [W:0] held_val;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({ovf, y}), 32'(held_val));
            end
            if (in_valid && in_ready) begin
                q_m.push_back(exp_in);
                pushes_m++;
            end
            if (out_valid && out_ready) begin
                if (q_m.size() == 0) check("main_spurious_out", 32'd1, 32'd0);
                else check("main_out", 32'({ovf, y}), 32'(q_m.pop_front()));
                pops_m++;
                pop_cyc.push_back(cyc);
            end
            held     = out_valid && !out_ready;
            held_val = {ovf, y};
        end
    end

    // Scoreboards for the STAGES=1 / STAGES=8 builds
    logic [W:0] q_x0 [$];
    logic [W:0] q_x1 [$];
    int pushes_x [2] = '{0, 0};
    int pops_x   [2] = '{0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            if (x_in_valid[0] && x_in_ready[0]) begin
                q_x0.push_back(model(x_a0[0], x_a1[0], x_op[0]));
                pushes_x[0]++;
            end
            if (x_out_valid[0] && x_out_ready[0]) begin
                if (q_x0.size() == 0) check("s1_spurious_out", 32'd1, 32'd0);
                else check("s1_out", 32'({x_ovf[0], x_y[0]}), 32'(q_x0.pop_front()));
                pops_x[0]++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (x_in_valid[1] && x_in_ready[1]) begin
                q_x1.push_back(model(x_a0[1], x_a1[1], x_op[1]));
                pushes_x[1]++;
            end
            if (x_out_valid[1] && x_out_ready[1]) begin
                if (q_x1.size() == 0) check("s8_spurious_out", 32'd1, 32'd0);
                else check("s8_out", 32'({x_ovf[1], x_y[1]}), 32'(q_x1.pop_front()));
                pops_x[1]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int   lat_m, lat_1, lat_8, acc, vi, seen, base;
        logic hs;
        logic hsx [2];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a0 = '0; a1 = '0; op = 1'b0; exp_in = '0;
        for (int k = 0; k < 2; k++) begin
            x_in_valid[k] = 1'b0; x_out_ready[k] = 1'b0; x_op[k] = 1'b0;
            x_a0[k] = '0; x_a1[k] = '0;
        end

        //              a0        a1     op     wrap      sat      ovf
        vt[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 16'h0003, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1};
        vt[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
        vt[3] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0};
        vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1};
        vt[6] = '{16'h1234, 16'h0234, 1'b1, 16'h1000, 16'h1000, 1'b0};
        vt[7] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0};
        vt[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 16'h7FFF, 1'b1};

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_out_valid", 32'(out_valid), 32'd0);

        // Basic transfer and latency for all three builds
        @(posedge clk); #1;
        out_ready = 1'b1; apply(0);
        for (int k = 0; k < 2; k++) begin
            x_a0[k] = 16'h0001; x_a1[k] = 16'h0002; x_op[k] = 1'b0;
            x_in_valid[k] = 1'b1; x_out_ready[k] = 1'b1;
        end
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; x_in_valid[0] = 1'b0; x_in_valid[1] = 1'b0;
        lat_m = 0; lat_1 = 0; lat_8 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid && lat_m == 0) begin
                lat_m = k;
                check("basic_y", 32'(y), 32'h0003);
                check("basic_ovf", 32'(ovf), 32'd0);
            end
            if (x_out_valid[0] && lat_1 == 0) lat_1 = k;
            if (x_out_valid[1] && lat_8 == 0) lat_8 = k;
        end
        check("latency_stages2", 32'(lat_m), 32'd2);
        check("latency_stages1", 32'(lat_1), 32'd1);
        check("latency_stages8", 32'(lat_8), 32'd8);
        check("basic_single_result", 32'(pops_m), 32'd1);

        // Streaming: 9 back-to-back golden vectors
        pop_cyc.delete();
        base = pops_m;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1; apply(i);
            @(negedge clk);
            check("stream_accept", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("stream_count", 32'(pops_m - base), 32'd9);
        for (int i = 1; i < pop_cyc.size(); i++)
            check("stream_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

        // Backpressure: out_ready low for 5 cycles under continuous input
        @(posedge clk); #1;
        out_ready = 1'b0; apply(0);
        vi = 0; acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 4) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_accepts_when_full", 32'(acc), 32'd2);
                check("bp_out_valid_held", 32'(out_valid), 32'd1);
            end
            if (c == 5) check("bp_full_push_pop", 32'(in_ready), 32'd1);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                acc++; vi++;
                if (vi < 6) apply(vi);
                else in_valid = 1'b0;
            end
            if (c == 4) out_ready = 1'b1;
        end
        repeat (4) @(negedge clk);
        check("bp_total_accepts", 32'(acc), 32'd6);
        check("bp_no_loss", 32'(pops_m), 32'(pushes_m));
        check("bp_queue_empty", 32'(q_m.size()), 32'd0);

        // Reset mid-stream with two results in flight
        @(posedge clk); #1;
        out_ready = 1'b0; apply(6);
        @(posedge clk); #1; apply(7);
        @(posedge clk); #1; in_valid = 1'b0;
        #1;
        check("mid_rst_pipe_full", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        q_m.delete();
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_none_emitted", 32'(seen), 32'd0);

        // STAGES=1 / STAGES=8: random operands, random out_ready
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) hsx[k] = x_in_valid[k] && x_in_ready[k];
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (hsx[k] || !x_in_valid[k]) begin
                    x_in_valid[k] = ($urandom_range(0, 3) != 0);
                    x_a0[k] = rnd_operand();
                    x_a1[k] = rnd_operand();
                    x_op[k] = 1'($urandom_range(0, 1));
                end
                x_out_ready[k] = ($urandom_range(0, 2) != 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            x_in_valid[k] = 1'b0; x_out_ready[k] = 1'b1;
        end
        repeat (20) @(negedge clk);
        check("s1_no_loss", 32'(pops_x[0]), 32'(pushes_x[0]));
        check("s8_no_loss", 32'(pops_x[1]), 32'(pushes_x[1]));
        check("s1_queue_empty", 32'(q_x0.size()), 32'd0);
        check("s8_queue_empty", 32'(q_x1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
